// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, ASCII bounds, button indices and cursor width helper for game_flow_ctrl.
package game_pkg;
  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    START   = 3'd1,
    PLAY    = 3'd2,
    PAUSE   = 3'd3,
    FINISH  = 3'd4
  } game_state_e;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_CHOP  = 4;
  localparam int BTN_N     = 5;
  function automatic int cur_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: falling-edge press detector; history resets to ones so a button held through reset is not a press.
module btn_edge #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_btn,
  output logic [W-1:0] o_press
);
  logic [W-1:0] r_prev;
  always_ff @(negedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_prev <= '1;
    else          r_prev <= i_btn;
  assign o_press = i_btn & ~r_prev;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: WELCOME -> START -> PLAY <-> PAUSE -> FINISH sequencer, updated on the falling edge of vsync.
// Optional high-score latch enabled by defining HIGH_SCORE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NAME_LEN   = 3,
  parameter int FPS        = 60,
  parameter int START_SECS = 3,
  parameter int TIME_W     = 8,
  parameter int POINT_W    = 10
) (
  input  logic                       vsync,
  input  logic                       reset,
  input  logic                       pause,
  input  logic                       left,
  input  logic                       right,
  input  logic                       up,
  input  logic                       down,
  input  logic                       chop,
  input  logic [TIME_W-1:0]          time_left,
  input  logic [POINT_W-1:0]         point_total,
  output logic [2:0]                 game_state,
  output logic [NAME_LEN*8-1:0]      team_name,
  output logic [cur_w(NAME_LEN)-1:0] cursor,
  output logic [3:0]                 start_sec,
  output logic                       timer_go,
  output logic [POINT_W-1:0]         best_score,
  output logic [NAME_LEN*8-1:0]      best_name
);
  localparam int CW = cur_w(NAME_LEN);
  localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NAME_LEN - 1);
  localparam logic [FW-1:0] FRAME_END = FW'(FPS - 1);
  game_state_e            r_state, w_next;
  logic                   r_timer_go;
  logic [7:0]             r_name [NAME_LEN];
  logic [CW-1:0]          r_cursor;
  logic [3:0]             r_start_sec;
  logic [FW-1:0]          r_frame;
  logic [BTN_N-1:0]       w_press;
  logic [NAME_LEN*8-1:0]  w_name;
  logic w_chop, w_up, w_down, w_right, w_left, w_confirm, w_frame_end, w_start_done, w_time_out;
  btn_edge #(.W(BTN_N)) u_btn_edge (
    .i_clk   (vsync),
    .i_rst_n (reset),
    .i_btn   ({chop, up, down, right, left}),
    .o_press (w_press)
  );
  // One action per frame: chop > up > down > right > left
  assign w_chop       = w_press[BTN_CHOP];
  assign w_up         = ~w_chop & w_press[BTN_UP];
  assign w_down       = ~|w_press[BTN_N-1:BTN_UP] & w_press[BTN_DOWN];
  assign w_right      = ~|w_press[BTN_N-1:BTN_DOWN] & w_press[BTN_RIGHT];
  assign w_left       = ~|w_press[BTN_N-1:BTN_RIGHT] & w_press[BTN_LEFT];
  assign w_confirm    = w_chop | (w_right & (r_cursor == LAST));
  assign w_frame_end  = r_frame == FRAME_END;
  assign w_start_done = w_frame_end & (r_start_sec == 4'd1);
  assign w_time_out   = time_left == '0;
  always_ff @(negedge vsync or negedge reset)
    if (!reset) begin
      r_state    <= WELCOME;
      r_timer_go <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_timer_go <= w_next == PLAY;
    end
  always_comb begin
    w_next = WELCOME;
    case (r_state)
      WELCOME: w_next = w_confirm ? START : WELCOME;
      START:   w_next = w_start_done ? PLAY : START;
      PLAY:    w_next = w_time_out ? FINISH : pause ? PAUSE : PLAY;
      PAUSE:   w_next = pause ? PAUSE : PLAY;
      FINISH:  w_next = |w_press ? WELCOME : FINISH;
      default: w_next = WELCOME;
    endcase
  end
  always_ff @(negedge vsync or negedge reset)
    if (!reset) begin
      for (int k = 0; k < NAME_LEN; k++) r_name[k] <= ASCII_A;
      r_cursor    <= '0;
      r_start_sec <= 4'(START_SECS);
      r_frame     <= '0;
    end else begin
      case (r_state)
        WELCOME:
          if (w_confirm) begin
            r_cursor    <= '0;
            r_start_sec <= 4'(START_SECS);
            r_frame     <= '0;
          end else if (w_up)
            r_name[r_cursor] <= (r_name[r_cursor] == ASCII_A) ? ASCII_Z : r_name[r_cursor] - 8'd1;
          else if (w_down)
            r_name[r_cursor] <= (r_name[r_cursor] == ASCII_Z) ? ASCII_A : r_name[r_cursor] + 8'd1;
          else if (w_right)
            r_cursor <= r_cursor + 1'b1;
          else if (w_left && r_cursor != '0)
            r_cursor <= r_cursor - 1'b1;
        START: begin
          r_frame <= w_frame_end ? '0 : r_frame + 1'b1;
          if (w_frame_end) r_start_sec <= r_start_sec - 4'd1;
        end
        FINISH:
          if (|w_press) r_cursor <= '0;
        default: ;
      endcase
    end
  for (genvar i = 0; i < NAME_LEN; i++) begin : g_name
    assign w_name[8*i +: 8] = r_name[i];
  end
  assign game_state = r_state;
  assign team_name  = w_name;
  assign cursor     = r_cursor;
  assign start_sec  = r_start_sec;
  assign timer_go   = r_timer_go;
`ifdef HIGH_SCORE_EN
  logic [POINT_W-1:0]     r_best;
  logic [NAME_LEN*8-1:0]  r_best_name;
  // Strictly greater: a tie keeps the earlier holder
  always_ff @(negedge vsync or negedge reset)
    if (!reset) begin
      r_best      <= '0;
      r_best_name <= {NAME_LEN{ASCII_A}};
    end else if (r_state == PLAY && w_time_out && point_total > r_best) begin
      r_best      <= point_total;
      r_best_name <= w_name;
    end
  assign best_score = r_best;
  assign best_name  = r_best_name;
`else
  logic w_unused;
  assign w_unused   = ^point_total;
  assign best_score = '0;
  assign best_name  = '0;
`endif
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: table vectors, directed corner sequences and random frames checked against a rule-level model.
module tb_game_flow_ctrl;
  localparam int N = 3, FPS = 60, SECS = 3;
  localparam logic [4:0] B_L = 5'b00001, B_R = 5'b00010, B_D = 5'b00100, B_U = 5'b01000, B_C = 5'b10000;
  logic vsync = 1'b0, reset = 1'b0, pause = 1'b0;
  logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, chop = 1'b0;
  logic [7:0] time_left = 8'd50;
  logic [9:0] point_total = '0;
  logic [2:0] game_state;
  logic [23:0] team_name, best_name;
  logic [1:0] cursor;
  logic [3:0] start_sec;
  logic timer_go;
  logic [9:0] best_score;
  int n_cmp = 0, n_err = 0;
  int m_state, m_cur, m_sfr, m_best;
  logic [7:0] m_name [N];
  logic [4:0] m_prev;
  logic [23:0] m_best_name;

  game_flow_ctrl #(.NAME_LEN(N), .FPS(FPS), .START_SECS(SECS), .TIME_W(8), .POINT_W(10)) dut (
    .vsync(vsync), .reset(reset), .pause(pause), .left(left), .right(right), .up(up), .down(down),
    .chop(chop), .time_left(time_left), .point_total(point_total), .game_state(game_state),
    .team_name(team_name), .cursor(cursor), .start_sec(start_sec), .timer_go(timer_go),
    .best_score(best_score), .best_name(best_name)
  );

  initial forever #5 vsync = ~vsync;

  function automatic logic [23:0] m_pack();
    return {m_name[2], m_name[1], m_name[0]};
  endfunction

  task automatic m_reset();
    m_state = 0; m_cur = 0; m_sfr = 0; m_prev = 5'h1f; m_best = 0;
    for (int k = 0; k < N; k++) m_name[k] = 8'h41;
    m_best_name = {3{8'h41}};
  endtask

  task automatic m_confirm();
    m_state = 1; m_cur = 0; m_sfr = 0;
  endtask

  // Model: letters as 0..25 modular arithmetic; START timed by a single elapsed-frame count
  task automatic m_step(input logic [4:0] b, input logic p, input int tl, input int pt);
    logic [4:0] pr;
    pr = b & ~m_prev;
    m_prev = b;
    case (m_state)
      0: if (pr[4]) m_confirm();
         else if (pr[3]) m_name[m_cur] = 8'(65 + (int'(m_name[m_cur]) - 65 + 25) % 26);
         else if (pr[2]) m_name[m_cur] = 8'(65 + (int'(m_name[m_cur]) - 65 + 1) % 26);
         else if (pr[1]) begin if (m_cur == N - 1) m_confirm(); else m_cur++; end
         else if (pr[0] && m_cur > 0) m_cur--;
      1: begin m_sfr++; if (m_sfr == SECS * FPS) m_state = 2; end
      2: if (tl == 0) begin
           m_state = 4;
           if (pt > m_best) begin m_best = pt; m_best_name = m_pack(); end
         end else if (p) m_state = 3;
      3: if (!p) m_state = 2;
      default: if (pr != 0) begin m_state = 0; m_cur = 0; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(game_state), 32'(m_state));
    chk("name", 32'(team_name), 32'(m_pack()));
    chk("cursor", 32'(cursor), 32'(m_cur));
    chk("start_sec", 32'(start_sec), 32'(SECS - m_sfr / FPS));
    chk("timer_go", 32'(timer_go), 32'(m_state == 2));
`ifdef HIGH_SCORE_EN
    chk("best_score", 32'(best_score), 32'(m_best));
    chk("best_name", 32'(best_name), 32'(m_best_name));
`else
    chk("best_score", 32'(best_score), 32'd0);
    chk("best_name", 32'(best_name), 32'd0);
`endif
  endtask

  task automatic frame(input logic [4:0] b, input logic p, input int tl, input int pt);
    @(posedge vsync);
    {chop, up, down, right, left} = b;
    pause = p; time_left = 8'(tl); point_total = 10'(pt);
    @(negedge vsync);
    #1;
    m_step(b, p, tl, pt);
    compare_all();
  endtask

  task automatic play_game(input logic [4:0] edit, input int pt);
    frame(edit, 0, 50, 0); frame(0, 0, 50, 0);
    frame(B_C, 0, 50, 0); frame(0, 0, 50, 0);
    repeat (SECS * FPS) frame(0, 0, 50, 0);
    frame(0, 0, 0, pt);
    chk("game_finish", 32'(game_state), 32'd4);
    frame(B_C, 0, 50, 0); frame(0, 0, 50, 0);
  endtask

  typedef struct {
    logic [4:0]  b;
    logic [2:0]  st;
    logic [1:0]  cur;
    logic [23:0] name;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic [4:0] rb;
    logic rp;
    tbl[0] = '{B_D, 3'd0, 2'd0, 24'h414142};
    tbl[1] = '{5'd0, 3'd0, 2'd0, 24'h414142};
    tbl[2] = '{B_D, 3'd0, 2'd0, 24'h414143};
    tbl[3] = '{5'd0, 3'd0, 2'd0, 24'h414143};
    tbl[4] = '{B_D | B_R, 3'd0, 2'd0, 24'h414144};
    tbl[5] = '{5'd0, 3'd0, 2'd0, 24'h414144};
    tbl[6] = '{B_R, 3'd0, 2'd1, 24'h414144};
    tbl[7] = '{5'd0, 3'd0, 2'd1, 24'h414144};
    tbl[8] = '{B_U, 3'd0, 2'd1, 24'h415A44};
    m_reset();
    repeat (2) @(negedge vsync);
    #1;
    compare_all();
    chk("rst_name", 32'(team_name), 32'h414141);
    @(posedge vsync); reset = 1'b1;
    frame(0, 0, 50, 0);
    foreach (tbl[i]) begin
      frame(tbl[i].b, 0, 50, 0);
      chk("tbl_state", 32'(game_state), 32'(tbl[i].st));
      chk("tbl_cursor", 32'(cursor), 32'(tbl[i].cur));
      chk("tbl_name", 32'(team_name), 32'(tbl[i].name));
    end
    frame(0, 0, 50, 0); frame(B_R, 0, 50, 0);
    chk("cur_last", 32'(cursor), 32'd2);
    frame(0, 0, 50, 0); frame(B_R, 0, 50, 0);
    chk("confirm_start", 32'(game_state), 32'd1);
    chk("start_sec3", 32'(start_sec), 32'd3);
    for (int f = 1; f <= SECS * FPS; f++) begin
      frame(0, 0, 50, 0);
      if (f == 60) chk("start_sec2", 32'(start_sec), 32'd2);
      if (f == 120) chk("start_sec1", 32'(start_sec), 32'd1);
      if (f == 179) chk("still_start", 32'(game_state), 32'd1);
    end
    chk("play_at_180", 32'(game_state), 32'd2);
    chk("play_go", 32'(timer_go), 32'd1);
    repeat (10) frame(0, 1, 50, 0);
    chk("paused", 32'(game_state), 32'd3);
    chk("paused_go", 32'(timer_go), 32'd0);
    frame(0, 0, 50, 0);
    chk("resume", 32'(game_state), 32'd2);
    frame(B_C, 1, 0, 120);
    chk("finish_over_pause", 32'(game_state), 32'd4);
    frame(B_C, 0, 50, 0);
    chk("held_stays_finish", 32'(game_state), 32'd4);
    frame(0, 0, 50, 0); frame(B_C, 0, 50, 0);
    chk("back_welcome", 32'(game_state), 32'd0);
    chk("name_kept", 32'(team_name), 32'h415A44);
    frame(0, 0, 50, 0);
    play_game(B_U, 90);
    play_game(B_D, 120);
`ifdef HIGH_SCORE_EN
    chk("hs_tie_score", 32'(best_score), 32'd120);
    chk("hs_tie_name", 32'(best_name), 32'h415A44);
`endif
    play_game(B_D, 121);
`ifdef HIGH_SCORE_EN
    chk("hs_new_score", 32'(best_score), 32'd121);
    chk("hs_new_name", 32'(best_name), 32'(m_pack()));
`endif
    frame(B_C, 0, 50, 0);
    repeat (75) frame(B_C, 0, 50, 0);
    reset = 1'b0;
    #1;
    m_reset();
    compare_all();
    chk("mid_rst_state", 32'(game_state), 32'd0);
    chk("mid_rst_sec", 32'(start_sec), 32'd3);
    @(posedge vsync); reset = 1'b1;
    frame(B_C, 0, 50, 0);
    chk("held_no_action", 32'(game_state), 32'd0);
    frame(0, 0, 50, 0);
    rb = '0; rp = 1'b0;
    for (int f = 0; f < 2500; f++) begin
      for (int k = 0; k < 5; k++) if ($urandom_range(0, 3) == 0) rb[k] = ~rb[k];
      if ($urandom_range(0, 9) == 0) rp = ~rp;
      frame(rb, rp, ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 255)), int'($urandom_range(0, 1023)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised successor of the top-level game-flow controller, sitting in the main FPGA control path beside the orders/points and action blocks. Sequences WELCOME (N-letter team-name entry) -> START (seconds countdown) -> PLAY <-> PAUSE -> FINISH -> WELCOME. All button inputs are edge-detected: one action per press, with no per-action "wait for release" states. Drives timer_go and a countdown display.

Parameters:
NAME_LEN, 3, number of team-name letters (1..8)
FPS, 60, vsync frames per second
START_SECS, 3, START countdown length in seconds (1..15)
TIME_W, 8, width of time_left
POINT_W, 10, width of point_total

Ports:
vsync  in  1  frame clock; all state updates on falling edge
reset  in  1  asynchronous, active-low reset
pause  in  1  level pause request
left, right, up, down, chop  in  1 each  raw button levels (already synchronous to vsync)
time_left  in  TIME_W  remaining game time from timer
point_total  in  POINT_W  current score
game_state  out  3  0 WELCOME, 1 START, 2 PLAY, 3 PAUSE, 4 FINISH
team_name  out  NAME_LEN x 8  ASCII letters; index 0 is leftmost
cursor  out  max(1,$clog2(NAME_LEN))  letter under edit
start_sec  out  4  seconds remaining in START
timer_go  out  1  high only in PLAY
best_score  out  POINT_W  (HIGH_SCORE_EN)
best_name  out  NAME_LEN x 8  (HIGH_SCORE_EN)

Behaviour:
- Reset (reset=0, async, immediate, also mid-game): game_state=WELCOME; every letter=8'h41 'A'; cursor=0; start_sec=START_SECS; frame counter=0; timer_go=0; button history = all ones, so a button held through reset does not register as a press.
- Press event: btn & ~btn_prev, history updated every frame. Only one press is acted on per frame. Priority: chop > up > down > right > left.
- WELCOME:
  - up: letter[cursor] decrements; 'A' wraps to 'Z'.
  - down: letter[cursor] increments; 'Z' wraps to 'A'.
  - right: cursor+1. At cursor=NAME_LEN-1, right confirms.
  - left: cursor-1. No effect at cursor 0.
  - chop: confirms.
  - Confirm -> START next frame; cursor=0, start_sec=START_SECS, frame counter=0.
- START: frame counter counts 0..FPS-1.
  - At FPS-1: counter returns to 0 and start_sec decrements.
  - When start_sec==1 and counter==FPS-1: -> PLAY.
  - Total START duration is exactly START_SECS*FPS frames. Buttons and pause are ignored.
- PLAY: timer_go=1.
  - time_left==0 -> FINISH; this has priority over pause in the same frame.
  - Otherwise pause==1 -> PAUSE.
- PAUSE: timer_go=0. pause==0 -> PLAY. time_left is ignored.
- FINISH: timer_go=0. A press event on any of left/right/up/down/chop -> WELCOME with cursor=0. team_name is retained. A button held while entering FINISH does not exit.
- timer_go is registered, so it changes in the same frame as game_state.
- States 5..7 are unreachable; if decoded, go to WELCOME.

Optional Feature:
HIGH_SCORE_EN
- Defined:
  - On the PLAY->FINISH transition frame, if point_total > best_score, latch best_score<=point_total and best_name<=team_name.
  - A tie does not replace the held entry.
  - Reset clears best_score to 0 and best_name to all 'A'.
- Undefined: best_score and best_name are driven constant 0. The ports remain present and no comparator is built.

Decomposition:
- Shared package game_pkg holds:
  - the game_state enum (WELCOME..FINISH, 3 bits);
  - ASCII_A=8'h41 and ASCII_Z=8'h5A;
  - the button-index constants.
- One sub-module, btn_edge: parametrised width, async active-low reset, history reset to ones, outputs a press vector. It is instantiated once with width 5.

Test Plan:
- Reset, then 3x down press on letter 0, right, up on letter 1 -> team_name="DZA", cursor=1.
- NAME_LEN=3: right x3 from cursor 0 -> cursor 2 then START; start_sec goes 3,2,1 with FPS=60; PLAY entered exactly 180 frames after confirm, timer_go=1 that frame.
- In PLAY, assert pause and hold 10 frames -> PAUSE, timer_go=0; release -> PLAY. Then time_left=0 with pause=1 in the same frame -> FINISH, not PAUSE.
- FINISH entered with chop held -> stays FINISH; release then press chop -> WELCOME, name retained.
- Deassert reset mid-START (counter=75) -> immediate WELCOME, name all 'A', start_sec=3. A button held across reset release produces no action.
- HIGH_SCORE_EN: games scoring 120, 90, 120 -> best_score=120 with the first game's name; a later 121 replaces it.
